reqgnt_checker: RTL and testbench
=================================

# reqgnt_checker

Parametrised, synthesizable request/grant protocol checker. It watches N independent req/grant channel pairs and flags every handshake that breaks a configurable grant-latency window. Both the overlapping (grant in the request cycle) and non-overlapping (grant on a later cycle) rules are supported, selected by `MIN_LAT`. It sits passively beside any arbiter or handshake interface and reports errors through registered per-channel flags, a one-cycle error report and a saturating violation counter.

## Interface
- `N_CH`, 4, number of req/grant channel pairs (1..32)
- `MIN_LAT`, 1, minimum legal grant latency in cycles (0 = overlapping, 1 = next-cycle)
- `MAX_LAT`, 4, maximum legal grant latency in cycles (`MAX_LAT >= MIN_LAT`, `MAX_LAT <= 255`)
- `CNT_W`, 8, violation counter width
- `clk  in  1  clock`; all logic on rising edge
- `rst_n  in  1`; synchronous, active-low reset
- `req  in  N_CH`; per-channel request
- `grant  in  N_CH`; per-channel grant
- `clear  in  1`; synchronous clear of `err_flags` and `viol_cnt`
- `pend  out  N_CH`; channel has an outstanding request (state WAIT)
- `err_flags  out  N_CH`; sticky per-channel error flag
- `err_vld  out  1`; one-cycle pulse, one or more errors detected in the previous cycle
- `err_ch  out  $clog2(N_CH)` (minimum 1); lowest-numbered erroring channel of that cycle
- `err_type  out  2`; error type for `err_ch`: 0 SPURIOUS, 1 EARLY, 2 TIMEOUT, 3 DROP
- `viol_cnt  out  CNT_W`; saturating total error count

## Operation
- Each channel has its own FSM with states IDLE and WAIT, plus a latency counter `lat` that is 8 bits wide.
- Evaluation in IDLE:
  - `req=1, grant=0`: go to WAIT with `lat=1`. If `MIN_LAT=0` and `MAX_LAT=0`, raise TIMEOUT instead and stay in IDLE.
  - `req=1, grant=1`: legal if `MIN_LAT=0`, and the channel stays in IDLE. Otherwise raise EARLY and stay in IDLE.
  - `req=0, grant=1`: raise SPURIOUS.
- Evaluation in WAIT:
  - `grant=1` with `lat >= MIN_LAT`: legal, go to IDLE.
  - `grant=1` with `lat < MIN_LAT`: raise EARLY, go to IDLE.
  - `grant=0, req=0`: raise DROP, go to IDLE.
  - `grant=0, req=1`: if `lat == MAX_LAT`, raise TIMEOUT and go to IDLE; else increment `lat`.
- Priority within a channel: grant is checked before drop and timeout.
- Back-to-back requests: a request that completes in a cycle where `req` stays high starts a new request on the next cycle, not the same one.
- Each channel raises at most one error per cycle.
- Error reporting (all registered):
  - `err_flags[i]` is set for every erroring channel.
  - `err_vld` pulses.
  - `err_ch` and `err_type` carry the lowest-index erroring channel.
  - `viol_cnt` adds the popcount of erroring channels and saturates at all-ones.
- `clear`: zeroes `err_flags` and `viol_cnt`. If errors occur in the same cycle, the result is the new errors only: flags set, and the counter equals this cycle's popcount.
- `clear` does not affect the FSMs, `pend`, `err_vld`, `err_ch` or `err_type`.

## Timing
- Reset (`rst_n=0` at a clock edge):
  - all FSMs go to IDLE and `lat=0`;
  - `pend=0`, `err_flags=0`, `err_vld=0`, `err_ch=0`, `err_type=0`, `viol_cnt=0`.
- Reset mid-transaction abandons outstanding requests silently; no error is reported.
- Inputs are sampled on the rising edge. Cycle *t* is the edge where IDLE first sees `req=1`, and grant latency k is measured from *t*.
- `pend` rises at *t+1*.
- Error latency is 1 cycle. An error detected at edge *e* appears on `err_*`, `err_flags` and `viol_cnt` after edge *e*, and `err_vld` is high until edge *e+1*.
- TIMEOUT is detected at edge *t+MAX_LAT* and is visible after it.
- All outputs come directly from registers; there is no combinational input-to-output path.

## Configuration
- `REQGNT_CHK_ASSERT_EN` defined:
  - Per channel, a concurrent SVA property is compiled in: `req |-> ##[MIN_LAT:MAX_LAT] grant` (disabled when `!rst_n`).
  - Also compiled in: an immediate `$error` naming the channel and type whenever the RTL raises an error.
  - The assertions are clocked on `posedge clk`, use sampled values, and are simulation-only.
- Not defined: purely synthesizable RTL. Outputs are bit-identical in both builds.

## Test plan
- **Overlapping legal** (`MIN_LAT=0, MAX_LAT=2`): ch0 `req=1`, `grant=1` on the same edge, `req` dropped the next cycle. Required: `err_vld` never high, `viol_cnt=0`, `pend[0]` stays 0.
- **Early grant** (`MIN_LAT=1`): ch2 `req` and `grant` high on the same edge. Required: next cycle `err_vld=1`, `err_ch=2`, `err_type=1`, `err_flags=4'b0100`, `viol_cnt=1`.
- **Timeout** (`MAX_LAT=4`): ch1 `req` held high with no grant. Required: `pend[1]` goes 1 at *t+1*, `err_type=2` and `err_ch=1` visible after edge *t+4*, then `pend[1]=0`. Because `req` is still high, a new request starts and `pend[1]` is back at 1 one cycle later.
- **Simultaneous errors and clear**: ch3 SPURIOUS and ch1 DROP on the same edge, with `clear=1`. Required: `err_ch=1`, `err_type=3`, `err_flags=4'b1010`, `viol_cnt=2`.
- **Saturation and reset** (`CNT_W=2`): 5 SPURIOUS grants on ch0. Required: `viol_cnt` reads 1, 2, 3, 3, 3. Then `rst_n=0` during a ch2 WAIT. Required: all outputs 0 and no error reported.

Source files
------------

// File: rtl/reqgnt_checker_if.sv
// Request/grant bundle observed by reqgnt_checker, one bit per channel.
// Latency: none, plain wires.
// Backpressure: none, the checker only listens and never drives the bus.
interface reqgnt_checker_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] grant;

  // Requester/arbiter side drives the handshake.
  modport master (
    output req,
    output grant
  );

  // Checker side only observes it.
  modport slave (
    input req,
    input grant
  );
endinterface

// File: rtl/reqgnt_checker.sv
// Passive per-channel req/grant latency-window checker with error report and counter.
// Latency: errors detected at edge e are visible on all outputs right after edge e.
// Backpressure: none; observes only. Optional SVA/$error checks under REQGNT_CHK_ASSERT_EN.
module reqgnt_checker #(
  parameter  int N_CH    = 4,
  parameter  int MIN_LAT = 1,
  parameter  int MAX_LAT = 4,
  parameter  int CNT_W   = 8,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reqgnt_checker_if.slave      bus,
  input  logic                 clear,
  output logic [N_CH-1:0]      pend,
  output logic [N_CH-1:0]      err_flags,
  output logic                 err_vld,
  output logic [CH_W-1:0]      err_ch,
  output logic [1:0]           err_type,
  output logic [CNT_W-1:0]     viol_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [1:0] ET_SPURIOUS = 2'd0;
  localparam logic [1:0] ET_EARLY    = 2'd1;
  localparam logic [1:0] ET_TIMEOUT  = 2'd2;
  localparam logic [1:0] ET_DROP     = 2'd3;

  localparam logic [7:0] MIN_L = 8'(MIN_LAT);
  localparam logic [7:0] MAX_L = 8'(MAX_LAT);

  // Grant in the request cycle is legal only for an overlapping window.
  localparam bit OVERLAP  = (MIN_LAT == 0);
  // A zero-width window means any request not granted at once has timed out.
  localparam bit ZERO_WIN = (MIN_LAT == 0) && (MAX_LAT == 0);

  // Extra headroom so counter + popcount (up to 32) never wraps before saturation.
  localparam int SUM_W = CNT_W + 7;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  // Per-channel FSM and latency counter.
  logic [0:0]      state_q [N_CH];
  logic [0:0]      state_d [N_CH];
  logic [7:0]      lat_q   [N_CH];
  logic [7:0]      lat_d   [N_CH];

  // Per-channel error detection for the current edge.
  logic [N_CH-1:0] too_early;
  logic [N_CH-1:0] err_hit;
  logic [1:0]      err_code [N_CH];

  // Registered report.
  logic [N_CH-1:0]  err_flags_q, err_flags_d;
  logic             err_vld_q,   err_vld_d;
  logic [CH_W-1:0]  err_ch_q,    err_ch_d;
  logic [1:0]       err_type_q,  err_type_d;
  logic [CNT_W-1:0] viol_cnt_q,  viol_cnt_d;

  logic [6:0]       pop;
  logic [SUM_W-1:0] cnt_base;
  logic [SUM_W-1:0] cnt_sum;

  // lat < MIN_LAT via the borrow of a 9-bit subtraction, so a zero MIN_LAT needs no special case.
  always_comb begin
    too_early = '0;
    for (int i = 0; i < N_CH; i++) begin
      too_early[i] = 1'(({1'b0, lat_q[i]} - {1'b0, MIN_L}) >> 8);
    end
  end

  // Next-state logic of every channel FSM; grant wins over drop and timeout.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_d[i]  = state_q[i];
      lat_d[i]    = lat_q[i];
      err_hit[i]  = 1'b0;
      err_code[i] = ET_SPURIOUS;

      case (state_q[i])
        ST_IDLE: begin
          if (bus.req[i]) begin
            if (bus.grant[i]) begin
              // Same-cycle grant: the channel stays idle either way.
              if (!OVERLAP) begin
                err_hit[i]  = 1'b1;
                err_code[i] = ET_EARLY;
              end
            end else if (ZERO_WIN) begin
              err_hit[i]  = 1'b1;
              err_code[i] = ET_TIMEOUT;
            end else begin
              state_d[i] = ST_WAIT;
              lat_d[i]   = 8'd1;
            end
          end else if (bus.grant[i]) begin
            err_hit[i]  = 1'b1;
            err_code[i] = ET_SPURIOUS;
          end
        end

        default: begin
          if (bus.grant[i]) begin
            state_d[i] = ST_IDLE;
            lat_d[i]   = 8'd0;
            if (too_early[i]) begin
              err_hit[i]  = 1'b1;
              err_code[i] = ET_EARLY;
            end
          end else if (!bus.req[i]) begin
            state_d[i]  = ST_IDLE;
            lat_d[i]    = 8'd0;
            err_hit[i]  = 1'b1;
            err_code[i] = ET_DROP;
          end else if (lat_q[i] == MAX_L) begin
            state_d[i]  = ST_IDLE;
            lat_d[i]    = 8'd0;
            err_hit[i]  = 1'b1;
            err_code[i] = ET_TIMEOUT;
          end else begin
            lat_d[i] = lat_q[i] + 8'd1;
          end
        end
      endcase
    end
  end

  // Aggregate: lowest erroring channel wins the report, all of them count.
  always_comb begin
    pop        = '0;
    err_ch_d   = err_ch_q;
    err_type_d = err_type_q;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (err_hit[i]) begin
        err_ch_d   = CH_W'(i);
        err_type_d = err_code[i];
      end
      pop = pop + 7'(err_hit[i]);
    end

    err_vld_d = |err_hit;

    // Clear drops history but keeps whatever is detected on this same edge.
    err_flags_d = (clear ? '0 : err_flags_q) | err_hit;

    cnt_base = clear ? '0 : SUM_W'(viol_cnt_q);
    cnt_sum  = cnt_base + SUM_W'(pop);
    if (cnt_sum > CNT_MAX) begin
      viol_cnt_d = '1;
    end else begin
      viol_cnt_d = cnt_sum[CNT_W-1:0];
    end
  end

  // Channel state registers; reset abandons outstanding requests silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_IDLE;
        lat_q[i]   <= 8'd0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        lat_q[i]   <= lat_d[i];
      end
    end
  end

  // Report registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_flags_q <= '0;
      err_vld_q   <= 1'b0;
      err_ch_q    <= '0;
      err_type_q  <= 2'd0;
      viol_cnt_q  <= '0;
    end else begin
      err_flags_q <= err_flags_d;
      err_vld_q   <= err_vld_d;
      err_ch_q    <= err_ch_d;
      err_type_q  <= err_type_d;
      viol_cnt_q  <= viol_cnt_d;
    end
  end

  // Outputs are straight register taps.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      pend[i] = (state_q[i] == ST_WAIT);
    end
  end

  assign err_flags = err_flags_q;
  assign err_vld   = err_vld_q;
  assign err_ch    = err_ch_q;
  assign err_type  = err_type_q;
  assign viol_cnt  = viol_cnt_q;

`ifdef REQGNT_CHK_ASSERT_EN
  function automatic string err_name(input logic [1:0] code);
    case (code)
      ET_SPURIOUS: return "SPURIOUS";
      ET_EARLY:    return "EARLY";
      ET_TIMEOUT:  return "TIMEOUT";
      default:     return "DROP";
    endcase
  endfunction

  for (genvar g = 0; g < N_CH; g++) begin : g_chk
    a_req_gnt: assert property (
      @(posedge clk) disable iff (!rst_n)
      bus.req[g] |-> ##[MIN_LAT:MAX_LAT] bus.grant[g]
    );

    // Name every violation the checker itself raises on this channel.
    always_ff @(posedge clk) begin
      if (rst_n && err_hit[g]) begin
        $error("reqgnt_checker: channel %0d %s", g, err_name(err_code[g]));
      end
    end
  end
`else
  // Synthesizable build: no simulation checks compiled in.
`endif

endmodule

// File: tb/tb_reqgnt_checker.sv
// Directed self-checking bench for reqgnt_checker with three parameter sets.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; inputs are driven directly.
module tb_reqgnt_checker;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a: defaults (MIN_LAT=1, MAX_LAT=4, CNT_W=8)
  reqgnt_checker_if #(.N_CH(4)) a_if ();
  logic       clear_a;
  logic [3:0] pend_a, flags_a;
  logic       vld_a;
  logic [1:0] ch_a, type_a;
  logic [7:0] viol_a;

  // b: overlapping window MIN_LAT=0, MAX_LAT=2
  reqgnt_checker_if #(.N_CH(4)) b_if ();
  logic       clear_b;
  logic [3:0] pend_b, flags_b;
  logic       vld_b;
  logic [1:0] ch_b, type_b;
  logic [7:0] viol_b;

  // c: narrow counter CNT_W=2
  reqgnt_checker_if #(.N_CH(4)) c_if ();
  logic       clear_c;
  logic [3:0] pend_c, flags_c;
  logic       vld_c;
  logic [1:0] ch_c, type_c;
  logic [1:0] viol_c;

  reqgnt_checker #(.N_CH(4), .MIN_LAT(1), .MAX_LAT(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave), .clear(clear_a),
    .pend(pend_a), .err_flags(flags_a), .err_vld(vld_a),
    .err_ch(ch_a), .err_type(type_a), .viol_cnt(viol_a)
  );

  reqgnt_checker #(.N_CH(4), .MIN_LAT(0), .MAX_LAT(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave), .clear(clear_b),
    .pend(pend_b), .err_flags(flags_b), .err_vld(vld_b),
    .err_ch(ch_b), .err_type(type_b), .viol_cnt(viol_b)
  );

  reqgnt_checker #(.N_CH(4), .MIN_LAT(1), .MAX_LAT(4), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(c_if.slave), .clear(clear_c),
    .pend(pend_c), .err_flags(flags_c), .err_vld(vld_c),
    .err_ch(ch_c), .err_type(type_c), .viol_cnt(viol_c)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    rst_n = 1'b0;
    clear_a = 1'b0; clear_b = 1'b0; clear_c = 1'b0;
    a_if.req = '0; a_if.grant = '0;
    b_if.req = '0; b_if.grant = '0;
    c_if.req = '0; c_if.grant = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_pend",  32'(pend_a),  32'h0);
    check("rst_flags", 32'(flags_a), 32'h0);
    check("rst_vld",   32'(vld_a),   32'h0);
    check("rst_ch",    32'(ch_a),    32'h0);
    check("rst_type",  32'(type_a),  32'h0);
    check("rst_viol",  32'(viol_a),  32'h0);

    // Overlapping legal on b: grant in the request cycle
    b_if.req = 4'b0001; b_if.grant = 4'b0001;
    tick();
    check("ovl_vld0",  32'(vld_b),  32'h0);
    check("ovl_pend0", 32'(pend_b), 32'h0);
    b_if.req = '0; b_if.grant = '0;
    tick();
    check("ovl_vld1",  32'(vld_b),  32'h0);
    check("ovl_pend1", 32'(pend_b), 32'h0);
    check("ovl_viol",  32'(viol_b), 32'h0);

    // Timeout at MAX_LAT=2 on b
    b_if.req = 4'b0001;
    tick();
    check("b_to_pend_t1", 32'(pend_b), 32'h1);
    tick();
    check("b_to_vld_t1",  32'(vld_b),  32'h0);
    tick();
    check("b_to_vld_t2",  32'(vld_b),  32'h1);
    check("b_to_type",    32'(type_b), 32'h2);
    check("b_to_ch",      32'(ch_b),   32'h0);
    check("b_to_pend_t2", 32'(pend_b), 32'h0);
    b_if.req = '0;
    tick();
    check("b_to_vld_after", 32'(vld_b),  32'h0);
    check("b_to_viol",      32'(viol_b), 32'h1);

    // Early grant on a ch2
    a_if.req = 4'b0100; a_if.grant = 4'b0100;
    tick();
    check("early_vld",   32'(vld_a),   32'h1);
    check("early_ch",    32'(ch_a),    32'h2);
    check("early_type",  32'(type_a),  32'h1);
    check("early_flags", 32'(flags_a), 32'h4);
    check("early_viol",  32'(viol_a),  32'h1);
    a_if.req = '0; a_if.grant = '0;
    tick();
    check("early_pulse", 32'(vld_a),   32'h0);
    check("early_stick", 32'(flags_a), 32'h4);

    // Legal grant at latency 1 on a ch0
    a_if.req = 4'b0001;
    tick();
    check("legal_pend",  32'(pend_a), 32'h1);
    a_if.grant = 4'b0001;
    tick();
    check("legal_vld",   32'(vld_a),  32'h0);
    check("legal_pend2", 32'(pend_a), 32'h0);
    a_if.req = '0; a_if.grant = '0;
    tick();
    check("legal_vld2",  32'(vld_a),  32'h0);
    check("legal_viol",  32'(viol_a), 32'h1);

    // Timeout on a ch1 with MAX_LAT=4, then back-to-back restart
    a_if.req = 4'b0010;
    tick();
    check("to_pend_t",  32'(pend_a), 32'h2);
    tick();
    tick();
    tick();
    check("to_vld_t3",  32'(vld_a),  32'h0);
    check("to_pend_t3", 32'(pend_a), 32'h2);
    tick();
    check("to_vld_t4",  32'(vld_a),   32'h1);
    check("to_ch",      32'(ch_a),    32'h1);
    check("to_type",    32'(type_a),  32'h2);
    check("to_pend_t4", 32'(pend_a),  32'h0);
    check("to_flags",   32'(flags_a), 32'h6);
    check("to_viol",    32'(viol_a),  32'h2);
    tick();
    check("to_restart", 32'(pend_a), 32'h2);
    check("to_vld_t5",  32'(vld_a),  32'h0);

    // ch1 DROP and ch3 SPURIOUS on one edge, together with clear
    a_if.req = '0; a_if.grant = 4'b1000; clear_a = 1'b1;
    tick();
    check("sim_vld",   32'(vld_a),   32'h1);
    check("sim_ch",    32'(ch_a),    32'h1);
    check("sim_type",  32'(type_a),  32'h3);
    check("sim_flags", 32'(flags_a), 32'ha);
    check("sim_viol",  32'(viol_a),  32'h2);
    a_if.grant = '0; clear_a = 1'b0;
    tick();
    check("sim_vld2",  32'(vld_a),  32'h0);
    check("sim_viol2", 32'(viol_a), 32'h2);

    // Plain clear leaves the report fields alone
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    check("clr_flags", 32'(flags_a), 32'h0);
    check("clr_viol",  32'(viol_a),  32'h0);
    check("clr_ch",    32'(ch_a),    32'h1);
    check("clr_type",  32'(type_a),  32'h3);

    // Saturation on c: consecutive SPURIOUS grants on ch0
    c_if.grant = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("sat%0d", k), 32'(viol_c), 32'(sat_exp[k]));
    end
    c_if.grant = '0;
    tick();

    // Reset in the middle of a ch2 wait
    c_if.req = 4'b0100;
    tick();
    check("c_pend", 32'(pend_c), 32'h4);
    rst_n = 1'b0;
    tick();
    check("rstw_pend",  32'(pend_c),  32'h0);
    check("rstw_flags", 32'(flags_c), 32'h0);
    check("rstw_vld",   32'(vld_c),   32'h0);
    check("rstw_ch",    32'(ch_c),    32'h0);
    check("rstw_type",  32'(type_c),  32'h0);
    check("rstw_viol",  32'(viol_c),  32'h0);
    c_if.req = '0;
    rst_n = 1'b1;
    tick();
    check("rstw_nodrop", 32'(vld_c),  32'h0);
    check("rstw_viol2",  32'(viol_c), 32'h0);
    check("rstw_pend2",  32'(pend_c), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
